// File: rtl/sram_resp_mem_pkg.sv
// Shared definitions for the SoC data-memory responder.
// - COUNT_OFS / SCRATCH_OFS: low 16 bits of the MMIO register addresses
// - target_t: decode result for one access
// - byte_merge: replaces the lanes of oldWord selected by wen with newWord
package soc_mem_pkg;

  localparam logic [15:0] COUNT_OFS   = 16'he000;
  localparam logic [15:0] SCRATCH_OFS = 16'hf000;

  typedef enum logic [1:0] {
    TGT_RAM,
    TGT_COUNT,
    TGT_SCRATCH,
    TGT_NONE
  } target_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [3:0]  wen);
    logic [31:0] merged;
    merged = oldWord;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) merged[8*i +: 8] = newWord[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_resp_mem_if.sv
// SRAM-like data port between the CPU (master) and the memory (slave).
// - sram_en/sram_wen/sram_addr/sram_wdata: access request, master -> slave
// - sram_rdata/err: response one cycle after the access, slave -> master
interface sram_if;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        err;

  modport master (
    output sram_en, sram_wen, sram_addr, sram_wdata,
    input  sram_rdata, err
  );

  modport slave (
    input  sram_en, sram_wen, sram_addr, sram_wdata,
    output sram_rdata, err
  );
endinterface

// File: rtl/sram_resp_mem_bytewise.sv
// Word-wide RAM with per-byte write enables, registered read, write-first.
// Written in the plain form that maps onto block RAM (no reset, single port).
// - clk: clock
// - en: access strobe; rdata only changes on an enabled cycle
// - wen: byte-lane write enables (0 = read)
// - addr: word index
// - wdata/rdata: write data in, registered read data out
module sram_bytewise
  import soc_mem_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      // Write-first: return the merged word on a write cycle.
      rdata <= byte_merge(mem[addr], wdata, wen);
    end
  end

endmodule

// File: rtl/sram_resp_mem.sv
// Data-memory responder: word RAM plus a free-running COUNT register and a
// SCRATCH register in the MMIO window; unmapped accesses pulse err.
// - clk/rst: clock, asynchronous active-high reset
// - bus (sram_if.slave): en/wen/addr/wdata in, rdata/err out, 1-cycle latency
module sram_resp_mem
  import soc_mem_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] MMIO_BASE = 32'h1faf_0000,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input logic   clk,
  input logic   rst,
  sram_if.slave bus
);

  target_t     tgt, tgtQ;
  logic        isWrite, ramEn, countWr, scratchWr;
  logic [31:0] countQ, scratchQ, mmioQ, mmioData, ramQ;
  logic [31:0] countMerged, scratchMerged;
  logic        errQ;
  logic        unusedAddrBits;

  assign unusedAddrBits = &{1'b0, bus.sram_addr[1:0]};

  always_comb begin
    tgt = TGT_NONE;
    if (bus.sram_addr[31:ADDR_W+2] == '0) begin
      tgt = TGT_RAM;
    end else if (bus.sram_addr[31:16] == MMIO_BASE[31:16]) begin
      if (bus.sram_addr[15:2] == COUNT_OFS[15:2])        tgt = TGT_COUNT;
      else if (bus.sram_addr[15:2] == SCRATCH_OFS[15:2]) tgt = TGT_SCRATCH;
    end
  end

  assign isWrite       = |bus.sram_wen;
  assign ramEn         = bus.sram_en && (tgt == TGT_RAM);
  assign countWr       = bus.sram_en && isWrite && (tgt == TGT_COUNT);
  assign scratchWr     = bus.sram_en && isWrite && (tgt == TGT_SCRATCH);
  assign countMerged   = byte_merge(countQ, bus.sram_wdata, bus.sram_wen);
  assign scratchMerged = byte_merge(scratchQ, bus.sram_wdata, bus.sram_wen);

  // Read data for the non-RAM targets; writes return the merged word.
  always_comb begin
    mmioData = ERR_RDATA;
    case (tgt)
      TGT_COUNT:   mmioData = isWrite ? countMerged : countQ;
      TGT_SCRATCH: mmioData = isWrite ? scratchMerged : scratchQ;
      default:     mmioData = ERR_RDATA;
    endcase
  end

  sram_bytewise #(.ADDR_W(ADDR_W)) uRam (
    .clk   (clk),
    .en    (ramEn),
    .wen   (bus.sram_wen),
    .addr  (bus.sram_addr[ADDR_W+1:2]),
    .wdata (bus.sram_wdata),
    .rdata (ramQ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      countQ   <= '0;
      scratchQ <= '0;
      mmioQ    <= '0;
      tgtQ     <= TGT_NONE;
      errQ     <= 1'b0;
    end else begin
      // A write to COUNT replaces that cycle's increment.
      countQ <= countWr ? countMerged : countQ + 32'd1;
      if (scratchWr) scratchQ <= scratchMerged;
      errQ <= bus.sram_en && (tgt == TGT_NONE);
      // Target select and MMIO data only move on an access so rdata holds when idle.
      if (bus.sram_en) begin
        tgtQ <= tgt;
        if (tgt != TGT_RAM) mmioQ <= mmioData;
      end
    end
  end

  // tgtQ resets to TGT_NONE so rdata reads the cleared mmioQ, not the unreset RAM.
  assign bus.sram_rdata = (tgtQ == TGT_RAM) ? ramQ : mmioQ;
  assign bus.err        = errQ;

endmodule

// File: tb/tb_sram_resp_mem.sv
module tb_sram_resp_mem;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sram_if busIf ();

  sram_resp_mem dut (
    .clk (clk),
    .rst (rst),
    .bus (busIf)
  );

  localparam logic [31:0] A_COUNT   = 32'h1faf_e000;
  localparam logic [31:0] A_SCRATCH = 32'h1faf_f000;
  localparam logic [31:0] A_BAD     = 32'h2000_0000;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       tag;
  } exp_t;

  exp_t        sbQ[$];
  logic [31:0] mRam[int unsigned];
  logic [31:0] mCount, mScratch, mLast;

  function automatic logic [31:0] mergeModel(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] w);
    logic [31:0] r;
    for (int b = 0; b < 32; b++) r[b] = w[b/8] ? n[b] : o[b];
    return r;
  endfunction

  task automatic checkOut(input string tag, input logic [31:0] expRd, input logic expErr);
    checks++;
    assert (busIf.sram_rdata === expRd) else begin
      failures++;
      $error("FAIL %s rdata got=%h exp=%h", tag, busIf.sram_rdata, expRd);
    end
    checks++;
    assert (busIf.err === expErr) else begin
      failures++;
      $error("FAIL %s err got=%b exp=%b", tag, busIf.err, expErr);
    end
  endtask

  // Called at a negedge; returns at the next negedge after one rising edge.
  task automatic access(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag);
    exp_t        e;
    logic        isRam, isCnt, isScr;
    logic [31:0] oldW, newW;
    busIf.sram_en    = en;
    busIf.sram_wen   = wen;
    busIf.sram_addr  = addr;
    busIf.sram_wdata = wdata;
    isRam = (addr >> 14) == 0;
    isCnt = addr[31:16] == 16'h1faf && addr[15:2] == 14'h3800;
    isScr = addr[31:16] == 16'h1faf && addr[15:2] == 14'h3c00;
    e.tag = tag;
    e.err = 1'b0;
    e.rdata = mLast;
    newW = 32'h0;
    if (en) begin
      if (isRam)      oldW = mRam.exists(int'(addr[13:2])) ? mRam[int'(addr[13:2])] : 32'hx;
      else if (isCnt) oldW = mCount;
      else if (isScr) oldW = mScratch;
      else            oldW = 32'h0;
      newW = mergeModel(oldW, wdata, wen);
      if (!(isRam || isCnt || isScr)) begin
        e.err = 1'b1;
        e.rdata = 32'h0;
      end else begin
        e.rdata = newW;
        if (wen != 4'b0) begin
          if (isRam) mRam[int'(addr[13:2])] = newW;
          if (isScr) mScratch = newW;
        end
      end
    end
    mCount = (en && wen != 4'b0 && isCnt) ? newW : mCount + 32'd1;
    mLast = e.rdata;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    e = sbQ.pop_front();
    checkOut(e.tag, e.rdata, e.err);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) access(1'b0, 4'h0, 32'h0, 32'h0, "idle");
  endtask

  task automatic doReset();
    rst = 1'b1;
    busIf.sram_en = 1'b0;
    #1;
    checkOut("midreset", 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mCount = 32'h0;
    mScratch = 32'h0;
    mLast = 32'h0;
  endtask

  initial begin
    busIf.sram_en = 1'b0;
    busIf.sram_wen = 4'h0;
    busIf.sram_addr = 32'h0;
    busIf.sram_wdata = 32'h0;
    mCount = 32'h0;
    mScratch = 32'h0;
    mLast = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOut("reset", 32'h0, 1'b0);
    rst = 1'b0;

    idle(5);
    access(1'b1, 4'h0, A_COUNT, 32'h0, "count_after_idle");

    access(1'b1, 4'hf, 32'h0000_0010, 32'h1122_3344, "wr_full");
    access(1'b1, 4'h0, 32'h0000_0010, 32'h0, "rd_full");
    access(1'b1, 4'hf, 32'h0000_0000, 32'h0bad_beef, "wr_word0");
    access(1'b1, 4'hf, A_SCRATCH, 32'h1234_5678, "wr_scratch");
    access(1'b1, 4'h0, A_SCRATCH, 32'h0, "rd_scratch");
    access(1'b1, 4'b0100, 32'h0000_0010, 32'haabb_ccdd, "wr_partial");
    access(1'b1, 4'h0, 32'h0000_0010, 32'h0, "rd_partial");
    access(1'b1, 4'b1001, A_SCRATCH, 32'hdead_0000, "wr_scratch_part");
    access(1'b1, 4'h0, A_SCRATCH, 32'h0, "rd_scratch_part");

    access(1'b1, 4'hf, A_COUNT, 32'hffff_fffe, "wr_count");
    access(1'b1, 4'h0, A_COUNT, 32'h0, "rd_count_ffff");
    idle(1);
    access(1'b1, 4'h0, A_COUNT, 32'h0, "rd_count_wrap");
    access(1'b1, 4'h0, A_COUNT, 32'h0, "rd_count_next");

    access(1'b1, 4'h0, A_BAD, 32'h0, "rd_unmapped");
    idle(1);
    access(1'b1, 4'hf, A_BAD, 32'h5555_aaaa, "wr_unmapped");
    access(1'b1, 4'h0, 32'h0000_0000, 32'h0, "rd_word0_kept");
    access(1'b1, 4'h0, A_SCRATCH, 32'h0, "rd_scratch_kept");
    access(1'b1, 4'h0, 32'h1faf_e004, 32'h0, "rd_mmio_hole");

    access(1'b1, 4'hf, 32'h0000_0014, 32'h7777_1234, "b2b_wr");
    access(1'b1, 4'h0, 32'h0000_0014, 32'h0, "b2b_rd");
    access(1'b1, 4'h0, 32'h0000_3ffc, 32'h0, "rd_ram_top_x");
    sbQ.delete();

    access(1'b1, 4'hf, A_SCRATCH, 32'hcafe_f00d, "wr_scratch_cafe");
    access(1'b1, 4'hf, 32'h0000_0020, 32'h0000_abcd, "wr_before_rst");
    doReset();
    access(1'b1, 4'h0, A_SCRATCH, 32'h0, "rst_scratch");
    access(1'b1, 4'h0, A_COUNT, 32'h0, "rst_count");
    access(1'b1, 4'h0, 32'h0000_0010, 32'h0, "rst_ram_kept");
    access(1'b1, 4'h0, 32'h0000_0020, 32'h0, "rst_ram_kept2");
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
